data_ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of `data_ram`. It shares the single data RAM between the multicycle datapath (port 0) and the program/data loader (port 1). It serialises their accesses with round-robin priority and drives the RAM's `address`/`memRead`/`memWrite`/`writeData`/`cs` pins. It returns read data to the winning requester with a one-cycle acknowledge pulse.

---
 rtl/data_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter that shares one data RAM between the datapath (port 0)
// and the loader (port 1), sequencing each access through IDLE/ACCESS/ACK.
module data_ram_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_memRead,
   output logic              ram_memWrite,
   output logic              ram_cs,
   output logic [DATA_W-1:0] ram_writeData,
   input  logic [DATA_W-1:0] ram_readData,
   output logic              busy,
   output logic              gnt_id
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t            state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic              gnt_id_q, gnt_id_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_write_data_q, ram_write_data_d;
   logic              ram_mem_read_q, ram_mem_read_d;
   logic              ram_mem_write_q, ram_mem_write_d;
   logic              ram_cs_q, ram_cs_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
   logic              sel;
   logic              sel_we;

   always_comb begin
      state_d          = state_q;
      last_gnt_d       = last_gnt_q;
      gnt_id_d         = gnt_id_q;
      busy_d           = busy_q;
      cnt_d            = cnt_q;
      ram_address_d    = ram_address_q;
      ram_write_data_d = ram_write_data_q;
      ram_mem_read_d   = ram_mem_read_q;
      ram_mem_write_d  = ram_mem_write_q;
      ram_cs_d         = ram_cs_q;
      p0_ack_d         = 1'b0;
      p1_ack_d         = 1'b0;
      p0_rdata_d       = p0_rdata_q;
      p1_rdata_d       = p1_rdata_q;
      // On a tie the port that did not win last time is chosen.
      sel              = p1_req && (!p0_req || !last_gnt_q);
      sel_we           = sel ? p1_we : p0_we;

      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               gnt_id_d         = sel;
               last_gnt_d       = sel;
               ram_address_d    = sel ? p1_addr : p0_addr;
               ram_write_data_d = sel ? p1_wdata : p0_wdata;
               ram_mem_read_d   = !sel_we;
               ram_mem_write_d  = sel_we;
               ram_cs_d         = 1'b1;
               cnt_d            = '0;
               busy_d           = 1'b1;
               state_d          = ACCESS;
            end
         end
         ACCESS: begin
            if (ram_mem_write_q || cnt_q == CNT_LAST) begin
               if (!ram_mem_write_q) begin
                  if (gnt_id_q) p1_rdata_d = ram_readData;
                  else          p0_rdata_d = ram_readData;
               end
               ram_mem_read_d  = 1'b0;
               ram_mem_write_d = 1'b0;
               ram_cs_d        = 1'b0;
               p0_ack_d        = !gnt_id_q;
               p1_ack_d        = gnt_id_q;
               state_d         = ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACK: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_gnt_q       <= 1'b1;
         gnt_id_q         <= 1'b0;
         busy_q           <= 1'b0;
         cnt_q            <= '0;
         ram_address_q    <= '0;
         ram_write_data_q <= '0;
         ram_mem_read_q   <= 1'b0;
         ram_mem_write_q  <= 1'b0;
         ram_cs_q         <= 1'b0;
         p0_ack_q         <= 1'b0;
         p1_ack_q         <= 1'b0;
         p0_rdata_q       <= '0;
         p1_rdata_q       <= '0;
      end else begin
         state_q          <= state_d;
         last_gnt_q       <= last_gnt_d;
         gnt_id_q         <= gnt_id_d;
         busy_q           <= busy_d;
         cnt_q            <= cnt_d;
         ram_address_q    <= ram_address_d;
         ram_write_data_q <= ram_write_data_d;
         ram_mem_read_q   <= ram_mem_read_d;
         ram_mem_write_q  <= ram_mem_write_d;
         ram_cs_q         <= ram_cs_d;
         p0_ack_q         <= p0_ack_d;
         p1_ack_q         <= p1_ack_d;
         p0_rdata_q       <= p0_rdata_d;
         p1_rdata_q       <= p1_rdata_d;
      end
   end

   assign p0_ack        = p0_ack_q;
   assign p1_ack        = p1_ack_q;
   assign p0_rdata      = p0_rdata_q;
   assign p1_rdata      = p1_rdata_q;
   assign ram_address   = ram_address_q;
   assign ram_memRead   = ram_mem_read_q;
   assign ram_memWrite  = ram_mem_write_q;
   assign ram_cs        = ram_cs_q;
   assign ram_writeData = ram_write_data_q;
   assign busy          = busy_q;
   assign gnt_id        = gnt_id_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each backed by a simple behavioural RAM.
module tb_data_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [9:0]  p0_addr = '0, p1_addr = '0;
   logic [63:0] p0_wdata = '0, p1_wdata = '0;
   logic        p0_ack, p1_ack, ram_memRead, ram_memWrite, ram_cs, busy, gnt_id;
   logic [63:0] p0_rdata, p1_rdata, ram_writeData, ram_readData;
   logic [9:0]  ram_address;

   logic        q0_req = 0, q0_we = 0, q1_req = 0, q1_we = 0;
   logic [9:0]  q0_addr = '0, q1_addr = '0;
   logic [63:0] q0_wdata = '0, q1_wdata = '0;
   logic        q0_ack, q1_ack, ram3_memRead, ram3_memWrite, ram3_cs, busy3, gnt_id3;
   logic [63:0] q0_rdata, q1_rdata, ram3_writeData, ram3_readData;
   logic [9:0]  ram3_address;

   logic [63:0] mem  [0:1023];
   logic [63:0] mem3 [0:1023];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   data_ram_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .ram_address(ram_address), .ram_memRead(ram_memRead), .ram_memWrite(ram_memWrite),
      .ram_cs(ram_cs), .ram_writeData(ram_writeData), .ram_readData(ram_readData),
      .busy(busy), .gnt_id(gnt_id)
   );

   data_ram_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset),
      .p0_req(q0_req), .p0_we(q0_we), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
      .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
      .p0_ack(q0_ack), .p0_rdata(q0_rdata), .p1_ack(q1_ack), .p1_rdata(q1_rdata),
      .ram_address(ram3_address), .ram_memRead(ram3_memRead), .ram_memWrite(ram3_memWrite),
      .ram_cs(ram3_cs), .ram_writeData(ram3_writeData), .ram_readData(ram3_readData),
      .busy(busy3), .gnt_id(gnt_id3)
   );

   // Behavioural RAMs: synchronous write, combinational read.
   always @(posedge clk) begin
      if (ram_cs && ram_memWrite) mem[ram_address] <= ram_writeData;
      if (ram3_cs && ram3_memWrite) mem3[ram3_address] <= ram3_writeData;
   end
   assign ram_readData  = mem[ram_address];
   assign ram3_readData = mem3[ram3_address];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input int port, input logic req, input logic we,
                                input logic [9:0] addr, input logic [63:0] wdata);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   initial begin
      // Reset held with a pending request: nothing may happen.
      applyStimulus(0, 1'b1, 1'b0, 10'd0, 64'd0);
      tick(); tick(); tick();
      checkOutput("rst_p0_ack", 64'(p0_ack), 64'd0);
      checkOutput("rst_ram_cs", 64'(ram_cs), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_gnt_id", 64'(gnt_id), 64'd0);
      checkOutput("rst_memrd", 64'(ram_memRead), 64'd0);
      checkOutput("rst_addr", 64'(ram_address), 64'd0);
      checkOutput("rst_wdata", ram_writeData, 64'd0);
      checkOutput("rst_p0_rdata", p0_rdata, 64'd0);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      reset = 1'b0;

      // p0 writes 10 to address 48.
      applyStimulus(0, 1'b1, 1'b1, 10'd48, 64'd10);
      tick();
      checkOutput("wr_cs", 64'(ram_cs), 64'd1);
      checkOutput("wr_memwr", 64'(ram_memWrite), 64'd1);
      checkOutput("wr_memrd", 64'(ram_memRead), 64'd0);
      checkOutput("wr_addr", 64'(ram_address), 64'd48);
      checkOutput("wr_data", ram_writeData, 64'd10);
      checkOutput("wr_busy", 64'(busy), 64'd1);
      checkOutput("wr_ack_early", 64'(p0_ack), 64'd0);
      tick();
      checkOutput("wr_ack", 64'(p0_ack), 64'd1);
      checkOutput("wr_cs_drop", 64'(ram_cs), 64'd0);
      checkOutput("wr_memwr_drop", 64'(ram_memWrite), 64'd0);
      checkOutput("wr_rdata_kept", p0_rdata, 64'd0);
      applyStimulus(0, 1'b0, 1'b0, 10'd48, 64'd0);
      tick();
      checkOutput("wr_ack_pulse", 64'(p0_ack), 64'd0);
      checkOutput("wr_idle_busy", 64'(busy), 64'd0);

      // p0 reads address 48 back.
      applyStimulus(0, 1'b1, 1'b0, 10'd48, 64'd0);
      tick();
      checkOutput("rd_memrd", 64'(ram_memRead), 64'd1);
      checkOutput("rd_memwr", 64'(ram_memWrite), 64'd0);
      checkOutput("rd_wdata_held", ram_writeData, 64'd0);
      tick();
      checkOutput("rd_ack", 64'(p0_ack), 64'd1);
      checkOutput("rd_p0_rdata", p0_rdata, 64'd10);
      checkOutput("rd_p1_rdata", p1_rdata, 64'd0);
      checkOutput("rd_p1_ack", 64'(p1_ack), 64'd0);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();

      // Preload address 5, then restart from reset.
      applyStimulus(0, 1'b1, 1'b1, 10'd5, 64'h55);
      tick(); tick();
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Simultaneous requests: p0 read 5, p1 write 0xDEAD to 6.
      applyStimulus(0, 1'b1, 1'b0, 10'd5, 64'd0);
      applyStimulus(1, 1'b1, 1'b1, 10'd6, 64'hDEAD);
      tick();
      checkOutput("tie_gnt0", 64'(gnt_id), 64'd0);
      checkOutput("tie_addr0", 64'(ram_address), 64'd5);
      tick();
      checkOutput("tie_ack0", 64'(p0_ack), 64'd1);
      checkOutput("tie_ack1_no", 64'(p1_ack), 64'd0);
      checkOutput("tie_rdata0", p0_rdata, 64'h55);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();
      checkOutput("tie_idle", 64'(busy), 64'd0);
      tick();
      checkOutput("tie_gnt1", 64'(gnt_id), 64'd1);
      checkOutput("tie_memwr1", 64'(ram_memWrite), 64'd1);
      checkOutput("tie_addr1", 64'(ram_address), 64'd6);
      checkOutput("tie_wdata1", ram_writeData, 64'hDEAD);
      tick();
      checkOutput("tie_ack1", 64'(p1_ack), 64'd1);
      checkOutput("tie_p1_rdata", p1_rdata, 64'd0);
      applyStimulus(1, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();
      checkOutput("tie_mem6", mem[6], 64'hDEAD);

      // Sustained dual reads: grants alternate starting with port 0.
      applyStimulus(0, 1'b1, 1'b0, 10'd5, 64'd0);
      applyStimulus(1, 1'b1, 1'b0, 10'd6, 64'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput($sformatf("alt_gnt%0d", k), 64'(gnt_id), 64'(k % 2));
         tick();
         checkOutput($sformatf("alt_ack%0d", k), {62'd0, p1_ack, p0_ack},
                     (k % 2 == 0) ? 64'd1 : 64'd2);
         tick();
      end
      checkOutput("alt_p0_rdata", p0_rdata, 64'h55);
      checkOutput("alt_p1_rdata", p1_rdata, 64'hDEAD);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      applyStimulus(1, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();

      // RD_LAT=3 instance: preload 100 via port 0, read it via port 1.
      q0_req = 1'b1; q0_we = 1'b1; q0_addr = 10'd100; q0_wdata = 64'hCAFEF00D12345678;
      tick(); tick();
      checkOutput("l3_wr_ack", 64'(q0_ack), 64'd1);
      q0_req = 1'b0;
      tick();
      q1_req = 1'b1; q1_we = 1'b0; q1_addr = 10'd100;
      for (int c = 1; c <= 3; c++) begin
         tick();
         checkOutput($sformatf("l3_memrd%0d", c), 64'(ram3_memRead), 64'd1);
         checkOutput($sformatf("l3_noack%0d", c), 64'(q1_ack), 64'd0);
      end
      tick();
      checkOutput("l3_ack", 64'(q1_ack), 64'd1);
      checkOutput("l3_memrd_drop", 64'(ram3_memRead), 64'd0);
      checkOutput("l3_rdata", q1_rdata, 64'hCAFEF00D12345678);
      checkOutput("l3_q0_rdata", q0_rdata, 64'd0);
      q1_req = 1'b0;
      tick();

      // Reset pulsed during a p1 read in ACCESS.
      applyStimulus(1, 1'b1, 1'b0, 10'd6, 64'd0);
      tick();
      checkOutput("ab_memrd", 64'(ram_memRead), 64'd1);
      checkOutput("ab_gnt", 64'(gnt_id), 64'd1);
      reset = 1'b1;
      tick();
      checkOutput("ab_cs", 64'(ram_cs), 64'd0);
      checkOutput("ab_memrd_drop", 64'(ram_memRead), 64'd0);
      checkOutput("ab_no_ack", 64'(p1_ack), 64'd0);
      checkOutput("ab_p1_rdata", p1_rdata, 64'd0);
      reset = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 10'd5, 64'd0);
      tick();
      checkOutput("ab_retie_gnt0", 64'(gnt_id), 64'd0);
      tick();
      checkOutput("ab_ack0", 64'(p0_ack), 64'd1);
      checkOutput("ab_ack1_no", 64'(p1_ack), 64'd0);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();
      tick();
      checkOutput("ab_gnt1", 64'(gnt_id), 64'd1);
      tick();
      checkOutput("ab_ack1", 64'(p1_ack), 64'd1);
      checkOutput("ab_rdata1", p1_rdata, 64'hDEAD);
      applyStimulus(1, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();

      // p0 keeps req high through ack with a new address.
      applyStimulus(0, 1'b1, 1'b0, 10'd48, 64'd0);
      tick();
      checkOutput("bk_addr1", 64'(ram_address), 64'd48);
      tick();
      checkOutput("bk_ack1", 64'(p0_ack), 64'd1);
      checkOutput("bk_rdata1", p0_rdata, 64'd10);
      applyStimulus(0, 1'b1, 1'b0, 10'd5, 64'd0);
      tick();
      checkOutput("bk_gap_ack", 64'(p0_ack), 64'd0);
      checkOutput("bk_gap_busy", 64'(busy), 64'd0);
      tick();
      checkOutput("bk_addr2", 64'(ram_address), 64'd5);
      checkOutput("bk_acc_ack", 64'(p0_ack), 64'd0);
      tick();
      checkOutput("bk_ack2", 64'(p0_ack), 64'd1);
      checkOutput("bk_rdata2", p0_rdata, 64'h55);
      applyStimulus(0, 1'b0, 1'b0, 10'd0, 64'd0);
      tick();
      checkOutput("bk_end_ack", 64'(p0_ack), 64'd0);
      tick();
      checkOutput("bk_end_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
